// File: rtl/pipe_stage.sv
// Two-entry skid-buffer pipeline stage (main + skid registers); all outputs come from registered state.
// Optional synchronous flush port enabled by defining PIPE_STAGE_FLUSH_EN.
module pipe_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
`ifdef PIPE_STAGE_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic [1:0]       w_state_next;
    logic             w_main_load;
    logic             w_main_from_skid;
    logic             w_skid_load;
    logic [WIDTH-1:0] w_main_next;
    logic             w_in_fire;
    logic             w_out_fire;

    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = (r_state != ST_TWO);
    assign out_data  = r_main;
    assign count     = (r_state == ST_TWO) ? 2'd2 :
                       (r_state == ST_ONE) ? 2'd1 : 2'd0;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_load  = 1'b1;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_load = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_load  = 1'b1;
                    w_state_next = ST_TWO;
                end else if (w_out_fire) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the drain path can move
                if (w_out_fire) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_next     = ST_ONE;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
`ifdef PIPE_STAGE_FLUSH_EN
        if (flush) begin
            w_state_next = ST_EMPTY;
            w_main_load  = 1'b0;
            w_skid_load  = 1'b0;
        end
`endif
    end

    assign w_main_next = w_main_from_skid ? r_skid : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else begin
            r_state <= w_state_next;
            if (w_main_load) r_main <= w_main_next;
            if (w_skid_load) r_skid <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage (WIDTH=8): directed scenarios plus random traffic against a FIFO-queue model.
// Flush scenarios are compiled in when PIPE_STAGE_FLUSH_EN is defined.
module tb_pipe_stage;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hC3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   count;
`ifdef PIPE_STAGE_FLUSH_EN
    logic         flush = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: the stage is a 2-deep FIFO whose head is what the stage presents
    logic [W-1:0] q[$];

    pipe_stage #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
`ifdef PIPE_STAGE_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and update the model from the pre-edge inputs; called at posedge+1
    task automatic edge_update();
        bit ifire;
        bit ofire;
        bit fl;
        logic [W-1:0] d;
        ifire = in_valid && (q.size() < 2);
        ofire = (q.size() > 0) && out_ready;
        d     = in_data;
        fl    = 1'b0;
`ifdef PIPE_STAGE_FLUSH_EN
        fl = flush;
`endif
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(d);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4 && q.size() != 0; i++) edge_update();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_edge got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_data !== RV) begin errors++; $display("FAIL reset_out_data got=%h exp=%h", out_data, RV); end
        rst = 1'b0;
        q.delete();
        $display("reset released");
    endtask

    task automatic test_streaming();
        drain();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
            edge_update();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++; $display("FAIL stream_out i=%0d got valid=%b data=%h exp valid=1 data=%h", i, out_valid, out_data, 8'(i));
            end else begin
                $display("stream xfer out=%h", out_data);
            end
        end
        in_valid = 1'b0;
        edge_update();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL stream_end got valid=%b count=%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'hA1; exp_seq[1] = 8'hA2; exp_seq[2] = 8'hA3;
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1; edge_update();
        in_data = 8'hA2; edge_update();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_count got=%0d exp=2", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        in_data = 8'hA3;
        repeat (2) begin
            edge_update();
            checks++; if (out_data !== 8'hA1 || count !== 2'd2) begin errors++; $display("FAIL bp_hold got data=%h count=%0d exp A1/2", out_data, count); end
        end
        // Drain while A3 is still offered; it must enter only once there is room
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[k]) begin
                errors++; $display("FAIL bp_order k=%0d got valid=%b data=%h exp %h", k, out_valid, out_data, exp_seq[k]);
            end else begin
                $display("bp xfer out=%h", out_data);
            end
            edge_update();
            in_valid = (k == 0);
        end
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL bp_end got valid=%b count=%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_simultaneous();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55; edge_update();
        checks++; if (out_data !== 8'h55 || count !== 2'd1) begin errors++; $display("FAIL simul_load got data=%h count=%0d exp 55/1", out_data, count); end
        in_data = 8'h66; out_ready = 1'b1; edge_update();
        checks++; if (out_data !== 8'h66 || count !== 2'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL simul_swap got data=%h count=%0d valid=%b exp 66/1/1", out_data, count, out_valid);
        end
        in_valid = 1'b0; edge_update();
        $display("simultaneous xfer done");
    endtask

    task automatic test_async_reset();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; edge_update();
        in_data = 8'h22; edge_update();
        in_valid = 1'b0;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL areset_pre_count got=%0d exp=2", count); end
        #3 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0 || out_data !== RV) begin
            errors++; $display("FAIL areset_immediate got valid=%b ready=%b count=%0d data=%h exp 0/1/0/%h", out_valid, in_ready, count, out_data, RV);
        end
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
        edge_update();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || count !== 2'd1) begin
            errors++; $display("FAIL areset_first got valid=%b data=%h count=%0d exp 1/3C/1", out_valid, out_data, count);
        end
        in_valid = 1'b0;
        drain();
    endtask

`ifdef PIPE_STAGE_FLUSH_EN
    task automatic test_flush();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; edge_update();
        in_data = 8'h02; edge_update();
        in_data = 8'h77; flush = 1'b1;
        edge_update();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got count=%0d valid=%b exp 0/0", count, out_valid); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            edge_update();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit got valid=%b data=%h exp valid=0", out_valid, out_data); end
        end
    endtask
`endif

    task automatic test_random();
        int max_cnt;
        drain();
        max_cnt = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef PIPE_STAGE_FLUSH_EN
            flush = ($urandom_range(0, 63) == 0);
`endif
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_out_valid c=%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, in_ready, q.size() < 2); end
            checks++; if (int'(count) != q.size()) begin errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, q.size()); end
            if (q.size() != 0) begin
                checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rand_out_data c=%0d got=%h exp=%h", c, out_data, q[0]); end
            end
            if (int'(count) > max_cnt) max_cnt = int'(count);
            edge_update();
        end
`ifdef PIPE_STAGE_FLUSH_EN
        flush = 1'b0;
`endif
        checks++; if (max_cnt > 2) begin errors++; $display("FAIL rand_count_bound got=%0d exp<=2", max_cnt); end
        drain();
        $display("random traffic done, peak count=%0d", max_cnt);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
`ifdef PIPE_STAGE_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
